// File: rtl/radio_spi_ctrl.sv
// rtl/radio_spi_ctrl.sv - SPI write controller for the radio transceiver (18-bit) and DAC (16-bit)
module radio_spi_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_target,
    input  logic [0:17] req_data,
    output logic        busy,
    output logic        done,
    output logic        controller_spi_clk,
    output logic        controller_spi_data,
    output logic        controller_radio_cs,
    output logic        controller_dac_cs
);
    typedef enum logic [2:0] {IDLE, SETUP, CLK_HI, CLK_LO, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    // GAP plus the done/IDLE cycle give exactly CLK_DIV CS-high cycles between words
    localparam logic [7:0] GAP_LAST = 8'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

    state_t      r_state;
    logic [7:0]  r_div;
    logic [4:0]  r_bit;
    logic [4:0]  r_last;
    logic [17:0] r_shift;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_sclk;
    logic        r_sdata;
    logic        r_rcs;
    logic        r_dcs;
    logic        w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_state <= IDLE;
            r_div   <= 8'd0;
            r_bit   <= 5'd0;
            r_last  <= 5'd0;
            r_shift <= 18'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_rcs   <= 1'b1;
            r_dcs   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_state <= SETUP;
                        r_shift <= req_data;
                        r_last  <= req_target ? 5'd15 : 5'd17;
                        r_bit   <= 5'd0;
                        r_div   <= 8'd0;
                        r_sdata <= req_data[0];
                        r_rcs   <= req_target;
                        r_dcs   <= !req_target;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (w_div_end) begin
                        r_div   <= 8'd0;
                        r_sclk  <= 1'b1;
                        r_state <= CLK_HI;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                CLK_HI: begin
                    if (w_div_end) begin
                        r_div   <= 8'd0;
                        r_sclk  <= 1'b0;
                        r_state <= CLK_LO;
                        // the last bit is held through its low phase rather than shifting in padding
                        if (r_bit != r_last) begin
                            r_shift <= {r_shift[16:0], 1'b0};
                            r_sdata <= r_shift[16];
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                CLK_LO: begin
                    if (w_div_end) begin
                        r_div <= 8'd0;
                        if (r_bit == r_last) begin
                            r_rcs   <= 1'b1;
                            r_dcs   <= 1'b1;
                            r_sdata <= 1'b0;
                            if (CLK_DIV == 1) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= GAP;
                            end
                        end else begin
                            r_bit   <= r_bit + 5'd1;
                            r_sclk  <= 1'b1;
                            r_state <= CLK_HI;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                GAP: begin
                    if (r_div == GAP_LAST) begin
                        r_div   <= 8'd0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready           = r_ready;
    assign busy                = r_busy;
    assign done                = r_done;
    assign controller_spi_clk  = r_sclk;
    assign controller_spi_data = r_sdata;
    assign controller_radio_cs = r_rcs;
    assign controller_dac_cs   = r_dcs;
endmodule
